vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Single-port arbiter and sequencer for the 1 bpp, 512×288 video RAM (9216 words × 16 bits). It sits between the TV-out timing/shift-out logic, a host port and a clear engine. Video fetches get fixed-latency absolute priority. The host and the built-in clear engine fill the remaining RAM cycles.

## Interface
- `DATA_W`, 16, video/host word width
- `ADDR_W`, 14, word address width
- `DEPTH`, 9216, number of valid words (addresses 0..DEPTH-1)

- `clk`  in  1  system clock (pixel strobe derived elsewhere)
- `rst_`  in  1  reset, asynchronous, active-low
- `vid_req`  in  1  one-cycle video fetch request
- `vid_addr`  in  ADDR_W  video word address, `{ypos, xpos[8:4]}` packed as index
- `vid_data`  out  DATA_W  fetched word
- `vid_valid`  out  1  `vid_data` strobe
- `host_valid`  in  1  host request present
- `host_ready`  out  1  host request accepted this cycle when both high
- `host_we`  in  1  1 = write, 0 = read
- `host_addr`  in  ADDR_W  host word address
- `host_wdata`  in  DATA_W  host write data
- `host_rdata`  out  DATA_W  host read data
- `host_rvalid`  out  1  `host_rdata` strobe
- `clr_start`  in  1  start clear/fill of whole RAM
- `clr_pattern`  in  DATA_W  fill word, latched at start
- `clr_busy`  out  1  clear in progress
- `clr_done`  out  1  one-cycle pulse after last fill write
- `mem_en`, `mem_we`  out  1 each  RAM strobes
- `mem_addr`  out  ADDR_W  RAM address
- `mem_wdata`  out  DATA_W  RAM write data
- `mem_rdata`  in  DATA_W  RAM read data, one cycle after `mem_en && !mem_we`

## Operation
- One RAM access per cycle. Priority: video > clear > host.
- States: IDLE, CLEAR.
  - IDLE→CLEAR on `clr_start`. `clr_pattern` is latched and the counter is zeroed.
  - CLEAR→IDLE after the write to DEPTH-1; `clr_done` pulses in that transition cycle+1.
  - `clr_start` in CLEAR is ignored.
- Video: `vid_req` drives the RAM combinationally in the same cycle (read, `vid_addr`). The clear counter and host are stalled for that cycle.
- Clear: in CLEAR, each cycle without `vid_req` writes `clr_pattern` to the counter address and increments the counter.
- Host: `host_ready = rst_ && state==IDLE && !vid_req`. On accept, a write goes to RAM directly; a read issues a RAM read.
- Read return path: a 2-stage source tag (none/video/host) follows each issued read, so returns never mix even when they are back-to-back.
- Out-of-range address (≥ DEPTH):
  - no RAM access (`mem_en`=0);
  - writes are dropped;
  - reads still return, with data 0 and the normal strobe at the normal latency.
- `mem_wdata` and `mem_we` are 0 whenever `mem_en`=0.

## Timing
- Reset values:
  - `vid_data`, `vid_valid`, `host_rdata`, `host_rvalid`, `clr_busy`, `clr_done` are all 0.
  - `host_ready` is 0 and all `mem_*` outputs are 0.
  - State is IDLE and the counter is 0.
- Video latency: `vid_req` in cycle N → `vid_valid`=1 with data registered in cycle N+2, for exactly one cycle. Fixed and never stalled.
- Host read latency: accept in cycle N → `host_rvalid` in N+2. One host read or write can be accepted per cycle.
- Clear duration: DEPTH + (number of `vid_req` cycles during the clear) cycles. `clr_busy` is high from the cycle after `clr_start` until the cycle `clr_done` pulses.
- Simultaneous events:
  - `vid_req` and `host_valid` together: video wins and the host waits, since `host_ready`=0.
  - `clr_start` and `host_valid` together in IDLE: the host is accepted that cycle, and CLEAR starts the next cycle.
- Reads already issued when a clear starts still return normally.
- Reset mid-clear: the next cycle is IDLE with `clr_busy`=0 and no `clr_done`. RAM contents are left partially filled. Pending read strobes are dropped.
- `vid_req` must not be asserted on consecutive cycles. The arbiter does not check this, but each request is still served.

## Configuration
- `VRAM_HOST_READ_EN` defined: host reads are supported as described above.
- Not defined:
  - a host request with `host_we`=0 is accepted and discarded, with no RAM access;
  - `host_rdata`/`host_rvalid` are tied to 0;
  - the return tag only tracks video.

## Test plan
- Host writes 16'hA5A5 to 0x1050; after it, `vid_req` at 0x1050 → 2 cycles later `vid_valid`=1 and `vid_data`=16'hA5A5.
- `vid_req` and host read of 0x0010 in the same cycle → `host_ready`=0 that cycle, the host is accepted the next cycle, and `host_rvalid` comes 1 cycle after `vid_valid`.
- `clr_start` with pattern 16'hFFFF and a `vid_req` every 16 cycles → `clr_done` after 9216 + (number of fetches) cycles; reading addresses 0, 4607 and 9215 returns 16'hFFFF.
- Host write to 9216 → `mem_en` stays 0. Host read of 9300 → `host_rvalid` with 0 after 2 cycles.
- Drop `rst_` at counter 100 during a clear → `clr_busy`=0, no `clr_done`; address 99 holds the pattern and address 100 holds its old value.
- Without `VRAM_HOST_READ_EN`: host read of 0 → accepted, `host_rvalid` never asserts, `mem_en` stays 0.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: video fetch, host port, clear control and RAM strobes of the
// video RAM arbiter grouped into one bundle. The arbiter uses the slave view;
// the surrounding logic (TV-out, host, RAM) uses the master view.
interface vram_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 14
);
  // video fetch port
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;
  // host port
  logic              host_valid;
  logic              host_ready;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
  // clear engine control
  logic              clr_start;
  logic [DATA_W-1:0] clr_pattern;
  logic              clr_busy;
  logic              clr_done;
  // single-port RAM
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  vid_req, vid_addr,
    output vid_data, vid_valid,
    input  host_valid, host_we, host_addr, host_wdata,
    output host_ready, host_rdata, host_rvalid,
    input  clr_start, clr_pattern,
    output clr_busy, clr_done,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output vid_req, vid_addr,
    input  vid_data, vid_valid,
    output host_valid, host_we, host_addr, host_wdata,
    input  host_ready, host_rdata, host_rvalid,
    output clr_start, clr_pattern,
    input  clr_busy, clr_done,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port arbiter and sequencer for the 1 bpp 512x288 video
// RAM (9216 x 16 bit words). Video fetches own the RAM whenever they request it
// and return with a fixed two-cycle latency; the clear engine and the host
// share the remaining cycles (priority video > clear > host).
// Optional feature macro VRAM_HOST_READ_EN: when defined, host reads are
// serviced through the RAM; when undefined, host reads are accepted and
// discarded and host_rdata/host_rvalid are held at 0.
module vram_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 9216
) (
  input logic           clk,
  input logic           rst_,
  vram_arbiter_if.slave bus
);

  // Addresses are compared one bit wider so DEPTH itself is representable.
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  // clear sequencer
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic              clr_done_q, clr_done_d;

  // read-return tag, stage 1 (RAM data is valid while the tag sits here)
  logic              vid_p1_q, vid_p1_d;
  logic              zero_p1_q, zero_p1_d;

  // read-return output stage
  logic [DATA_W-1:0] vid_data_q, vid_data_d;
  logic              vid_valid_q, vid_valid_d;
`ifdef VRAM_HOST_READ_EN
  logic              host_p1_q, host_p1_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              host_rvalid_q, host_rvalid_d;
`endif

  // combinational arbitration results
  logic              vid_in;
  logic              host_in;
  logic              host_ready;
  logic              host_acc;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  assign vid_in     = ({1'b0, bus.vid_addr}  < DEPTH_L);
  assign host_in    = ({1'b0, bus.host_addr} < DEPTH_L);
  // Reset is folded in so the host never sees a handshake while held in reset.
  assign host_ready = rst_ && (state_q == IDLE) && !bus.vid_req;
  assign host_acc   = bus.host_valid && host_ready;

  // Arbitrate the single RAM port, advance the clear sequencer, tag reads.
  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    pat_d      = pat_q;
    clr_done_d = 1'b0;
    vid_p1_d   = 1'b0;
    zero_p1_d  = 1'b0;
`ifdef VRAM_HOST_READ_EN
    host_p1_d  = 1'b0;
`endif

    if (bus.vid_req) begin
      // Video always wins; an out-of-range fetch still returns (as zero).
      vid_p1_d  = 1'b1;
      zero_p1_d = !vid_in;
      if (vid_in) begin
        mem_en   = 1'b1;
        mem_addr = bus.vid_addr;
      end
    end else if (state_q == CLEAR) begin
      // Counter only advances on cycles the video port left free.
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = cnt_q;
      mem_wdata = pat_q;
      if (cnt_q == LAST_ADDR) begin
        state_d    = IDLE;
        cnt_d      = '0;
        clr_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (host_acc) begin
      if (bus.host_we) begin
        // Out-of-range writes are silently dropped.
        if (host_in) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = bus.host_addr;
          mem_wdata = bus.host_wdata;
        end
      end
`ifdef VRAM_HOST_READ_EN
      else begin
        host_p1_d = 1'b1;
        zero_p1_d = !host_in;
        if (host_in) begin
          mem_en   = 1'b1;
          mem_addr = bus.host_addr;
        end
      end
`endif
    end

    // A start in IDLE takes effect next cycle, even if the host was served now.
    if ((state_q == IDLE) && bus.clr_start) begin
      state_d = CLEAR;
      cnt_d   = '0;
      pat_d   = bus.clr_pattern;
    end

    // Keep the RAM quiet while reset is held.
    if (!rst_) begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  // Capture returning RAM data for whichever source the stage-1 tag names.
  always_comb begin
    vid_valid_d = vid_p1_q;
    vid_data_d  = vid_data_q;
    if (vid_p1_q) begin
      vid_data_d = zero_p1_q ? '0 : bus.mem_rdata;
    end
`ifdef VRAM_HOST_READ_EN
    host_rvalid_d = host_p1_q;
    host_rdata_d  = host_rdata_q;
    if (host_p1_q) begin
      host_rdata_d = zero_p1_q ? '0 : bus.mem_rdata;
    end
`endif
  end

  // Sequencer state and read-return pipeline registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      pat_q         <= '0;
      clr_done_q    <= 1'b0;
      vid_p1_q      <= 1'b0;
      zero_p1_q     <= 1'b0;
      vid_data_q    <= '0;
      vid_valid_q   <= 1'b0;
`ifdef VRAM_HOST_READ_EN
      host_p1_q     <= 1'b0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pat_q         <= pat_d;
      clr_done_q    <= clr_done_d;
      vid_p1_q      <= vid_p1_d;
      zero_p1_q     <= zero_p1_d;
      vid_data_q    <= vid_data_d;
      vid_valid_q   <= vid_valid_d;
`ifdef VRAM_HOST_READ_EN
      host_p1_q     <= host_p1_d;
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
`endif
    end
  end

  assign bus.vid_data    = vid_data_q;
  assign bus.vid_valid   = vid_valid_q;
  assign bus.host_ready  = host_ready;
`ifdef VRAM_HOST_READ_EN
  assign bus.host_rdata  = host_rdata_q;
  assign bus.host_rvalid = host_rvalid_q;
`else
  assign bus.host_rdata  = '0;
  assign bus.host_rvalid = 1'b0;
`endif
  assign bus.clr_busy    = (state_q == CLEAR);
  assign bus.clr_done    = clr_done_q;
  assign bus.mem_en      = mem_en;
  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter with a behavioural RAM.
// Read expectations are queued when requests are issued; a negedge monitor
// pops and compares them whenever vid_valid / host_rvalid fire.
module tb_vram_arbiter;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 9216;
`ifdef VRAM_HOST_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   bad_idle = 0;
  int   bad_oob = 0;
  int   busy_bad = 0;
  exp_t vq[$];
  exp_t hq[$];

  vram_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bif ();

  vram_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] init_val(input int a);
    return DATA_W'(a) ^ 16'h5A00;
  endfunction

  // Behavioural single-port RAM: unwritten words read as init_val(addr).
  logic [DATA_W-1:0] ram [DEPTH];
  bit                written [DEPTH];
  always @(posedge clk) begin
    if (bif.mem_en && int'(bif.mem_addr) < DEPTH) begin
      if (bif.mem_we) begin
        ram[bif.mem_addr]     <= bif.mem_wdata;
        written[bif.mem_addr] <= 1'b1;
      end else begin
        bif.mem_rdata <= written[bif.mem_addr] ? ram[bif.mem_addr]
                                               : init_val(int'(bif.mem_addr));
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: scoreboard pops plus RAM-port protocol bookkeeping.
  always @(negedge clk) begin
    exp_t e;
    if (bif.vid_valid) begin
      check("vid_expected", 32'(vq.size() > 0), 1);
      if (vq.size() > 0) begin
        e = vq.pop_front();
        check("vid_data", bif.vid_data, e.data);
        check("vid_latency", cyc, e.cyc);
      end
    end
    if (bif.host_rvalid) begin
      check("host_rvalid_expected", 32'(hq.size() > 0), 1);
      if (hq.size() > 0) begin
        e = hq.pop_front();
        check("host_rdata", bif.host_rdata, e.data);
        check("host_latency", cyc, e.cyc);
      end
    end
    if (bif.clr_done) n_done++;
    if (!bif.mem_en && (bif.mem_we || bif.mem_wdata != '0)) bad_idle++;
    if (bif.mem_en && int'(bif.mem_addr) >= DEPTH) bad_oob++;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bif.vid_req     = 1'b0;
    bif.vid_addr    = '0;
    bif.host_valid  = 1'b0;
    bif.host_we     = 1'b0;
    bif.host_addr   = '0;
    bif.host_wdata  = '0;
    bif.clr_start   = 1'b0;
    bif.clr_pattern = '0;
  endtask

  // Video fetch in the current cycle, followed by a free cycle.
  task automatic vid_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp, input string nm);
    bif.vid_req  = 1'b1;
    bif.vid_addr = a;
    vq.push_back('{data: exp, cyc: cyc + 2});
    #1;
    check({nm, "_mem_en"}, bif.mem_en, 32'(int'(a) < DEPTH));
    if (bif.mem_en) begin
      check({nm, "_mem_we"}, bif.mem_we, 0);
      check({nm, "_mem_addr"}, bif.mem_addr, a);
    end
    step();
    bif.vid_req = 1'b0;
    step();
  endtask

  // Host transaction held until accepted (bounded).
  task automatic host_op(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                         input logic [DATA_W-1:0] exp_rd, input string nm);
    bit acc;
    bit exp_en;
    acc    = 1'b0;
    exp_en = (int'(a) < DEPTH) && (we || READ_EN);
    bif.host_valid = 1'b1;
    bif.host_we    = we;
    bif.host_addr  = a;
    bif.host_wdata = wd;
    for (int i = 0; i < 20 && !acc; i++) begin
      #1;
      if (bif.host_ready) begin
        acc = 1'b1;
        check({nm, "_mem_en"}, bif.mem_en, 32'(exp_en));
        if (exp_en) begin
          check({nm, "_mem_we"}, bif.mem_we, 32'(we));
          check({nm, "_mem_addr"}, bif.mem_addr, a);
          if (we) check({nm, "_mem_wdata"}, bif.mem_wdata, wd);
        end
        if (!we && READ_EN) hq.push_back('{data: exp_rd, cyc: cyc + 2});
      end
      step();
    end
    bif.host_valid = 1'b0;
    check({nm, "_accepted"}, 32'(acc), 1);
  endtask

  initial begin
    int s;
    int k;
    int nvid;
    int done_cyc;
    bit hit;

    // Reset with every request input active: outputs must stay quiet.
    rst_ = 1'b0;
    idle_inputs();
    bif.vid_req    = 1'b1;
    bif.vid_addr   = 14'h0010;
    bif.host_valid = 1'b1;
    bif.host_we    = 1'b1;
    bif.host_addr  = 14'h0005;
    bif.host_wdata = 16'h1234;
    bif.clr_start  = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_vid_valid", bif.vid_valid, 0);
    check("rst_vid_data", bif.vid_data, 0);
    check("rst_host_rvalid", bif.host_rvalid, 0);
    check("rst_host_rdata", bif.host_rdata, 0);
    check("rst_host_ready", bif.host_ready, 0);
    check("rst_clr_busy", bif.clr_busy, 0);
    check("rst_clr_done", bif.clr_done, 0);
    check("rst_mem_en", bif.mem_en, 0);
    check("rst_mem_we", bif.mem_we, 0);
    check("rst_mem_addr", bif.mem_addr, 0);
    check("rst_mem_wdata", bif.mem_wdata, 0);
    idle_inputs();
    @(posedge clk);
    #1;
    rst_ = 1'b1;
    #1;
    check("post_rst_ready", bif.host_ready, 1);
    check("post_rst_busy", bif.clr_busy, 0);
    step();

    // Host write then video fetch of the same word.
    host_op(1'b1, 14'h1050, 16'hA5A5, 16'h0000, "wr_1050");
    vid_read(14'h1050, 16'hA5A5, "vid_1050");

    // Video and host request collide: video wins, host follows next cycle.
    bif.vid_req  = 1'b1;
    bif.vid_addr = 14'h1050;
    vq.push_back('{data: 16'hA5A5, cyc: cyc + 2});
    bif.host_valid = 1'b1;
    bif.host_we    = 1'b0;
    bif.host_addr  = 14'h0010;
    #1;
    check("coll_host_ready", bif.host_ready, 0);
    check("coll_mem_addr", bif.mem_addr, 14'h1050);
    check("coll_mem_we", bif.mem_we, 0);
    step();
    bif.vid_req = 1'b0;
    host_op(1'b0, 14'h0010, 16'h0000, init_val(16), "coll_host");
    step();

`ifdef VRAM_HOST_READ_EN
    // Host read immediately followed by a video read: returns must not mix.
    host_op(1'b0, 14'h1050, 16'h0000, 16'hA5A5, "b2b_host");
    vid_read(14'h0010, init_val(16), "b2b_vid");
    // Out-of-range host read returns zero with normal timing.
    host_op(1'b0, 14'd9300, 16'h0000, 16'h0000, "oob_host_rd");
`else
    // Reads are accepted and discarded without touching the RAM.
    host_op(1'b0, 14'h0000, 16'h0000, 16'h0000, "nord_host");
`endif

    // Out-of-range host write is dropped; out-of-range video read returns 0.
    host_op(1'b1, 14'd9216, 16'hDEAD, 16'h0000, "oob_host_wr");
    vid_read(14'd9300, 16'h0000, "oob_vid");

    // Clear with 16'hFFFF, started together with an accepted host write.
    s = cyc;
    bif.clr_start   = 1'b1;
    bif.clr_pattern = 16'hFFFF;
    bif.host_valid  = 1'b1;
    bif.host_we     = 1'b1;
    bif.host_addr   = 14'h0005;
    bif.host_wdata  = 16'h1111;
    #1;
    check("clr_start_host_ready", bif.host_ready, 1);
    check("clr_start_host_addr", bif.mem_addr, 14'h0005);
    check("clr_start_busy", bif.clr_busy, 0);
    step();
    idle_inputs();
    check("clr_busy_rise", bif.clr_busy, 1);
    nvid     = 0;
    done_cyc = -1;
    for (int i = 0; i < 12000; i++) begin
      k = cyc - (s + 1);
      if (bif.clr_done) begin
        done_cyc = cyc;
        break;
      end
      if (!bif.clr_busy) busy_bad++;
      bif.vid_req     = (k % 16 == 15);
      bif.vid_addr    = '0;
      bif.clr_start   = (k == 1000);
      bif.clr_pattern = '0;
      if (bif.vid_req) begin
        nvid++;
        vq.push_back('{data: 16'hFFFF, cyc: cyc + 2});
      end
      step();
    end
    idle_inputs();
    check("clr_fetch_count", nvid, 614);
    check("clr_done_cycle", done_cyc, s + 1 + 9216 + 614);
    step();
    check("clr_done_pulse_width", bif.clr_done, 0);
    check("clr_busy_after", bif.clr_busy, 0);
    step();
    vid_read(14'd0, 16'hFFFF, "clr_rd_0");
    vid_read(14'd4607, 16'hFFFF, "clr_rd_4607");
    vid_read(14'd9215, 16'hFFFF, "clr_rd_9215");
    vid_read(14'd5, 16'hFFFF, "clr_rd_5");

    // Second clear, reset while the counter sits at 100 with a fetch pending.
    s = cyc;
    bif.clr_start   = 1'b1;
    bif.clr_pattern = 16'h1234;
    step();
    idle_inputs();
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      k = cyc - (s + 1);
      bif.vid_req  = (k == 100);
      bif.vid_addr = '0;
      #1;
      if (!bif.vid_req && bif.mem_we && bif.mem_addr == 14'd100) begin
        hit = 1'b1;
        rst_ = 1'b0;
        #1;
        check("midrst_busy", bif.clr_busy, 0);
        check("midrst_done", bif.clr_done, 0);
        check("midrst_mem_en", bif.mem_en, 0);
        step();
        rst_ = 1'b1;
        break;
      end
      step();
    end
    check("midrst_reached_100", 32'(hit), 1);
    idle_inputs();
    #1;
    check("midrst_idle_ready", bif.host_ready, 1);
    check("midrst_idle_busy", bif.clr_busy, 0);
    repeat (4) step();
    vid_read(14'd99, 16'h1234, "midrst_rd_99");
    vid_read(14'd100, 16'hFFFF, "midrst_rd_100");
    vid_read(14'd0, 16'h1234, "midrst_rd_0");

    repeat (6) step();
    check("vid_queue_drained", vq.size(), 0);
    check("host_queue_drained", hq.size(), 0);
    check("clr_done_pulses", n_done, 1);
    check("clr_busy_held", busy_bad, 0);
    check("mem_idle_quiet", bad_idle, 0);
    check("mem_no_oob_access", bad_oob, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
